// File: rtl/stop_count_rx.sv
// Decoder for the serial stop-delay pulse train: counts pulses, closes a burst on a low-gap
// timeout or tos_mark, and offers the count on valid/ready. Optional macro: STOP_COUNT_RX_SYNC_EN.
module stop_count_rx #(
    parameter int CountWidth = 14,
    parameter int GapCycles  = 4
) (
    input  logic                  clk_tf,
    input  logic                  rst,
    input  logic                  stop_tos_count,
    input  logic                  tos_mark,
    output logic [CountWidth-1:0] count_data,
    output logic                  count_sat,
    output logic                  count_valid,
    input  logic                  count_ready,
    output logic                  overrun_err,
    output logic                  pulse_err,
    output logic                  late_err,
    input  logic                  clr_flags
);
    localparam int GW = $clog2(GapCycles + 1);
    localparam logic [GW-1:0]         GAP_LAST = GW'(GapCycles - 1);
    localparam logic [CountWidth-1:0] CNT_MAX  = {CountWidth{1'b1}};

    typedef enum logic [1:0] {S_QUIET, S_IDLE, S_COUNT} state_e;

    state_e                state_q, state_d;
    logic                  in_q, in_p;
    logic [GW-1:0]         gap_q, gap_d;
    logic [CountWidth-1:0] run_q, run_d;
    logic                  sat_q, sat_d;
    logic [CountWidth-1:0] data_q;
    logic                  osat_q, valid_q;
    logic                  ovr_q, perr_q, lerr_q;
    logic                  din, tos_eff;
    logic                  edge_s, load, late_set, ovr_set, perr_set, xfer;

`ifdef STOP_COUNT_RX_SYNC_EN
    // tos_mark is not metastable-prone; it only rides a matching delay line.
    logic [1:0] sync_q, tos_dly_q;
    always_ff @(posedge clk_tf) begin
        if (rst) begin
            sync_q    <= '0;
            tos_dly_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], stop_tos_count};
            tos_dly_q <= {tos_dly_q[0], tos_mark};
        end
    end
    assign din     = sync_q[1];
    assign tos_eff = tos_dly_q[1];
`else
    assign din     = stop_tos_count;
    assign tos_eff = tos_mark;
`endif

    assign edge_s   = in_q & ~in_p;
    assign xfer     = valid_q & count_ready;
    assign ovr_set  = load & valid_q & ~count_ready;
    assign perr_set = (state_q != S_QUIET) & in_q & in_p;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        run_d    = run_q;
        sat_d    = sat_q;
        load     = 1'b0;
        late_set = 1'b0;
        case (state_q)
            S_QUIET: begin
                if (in_q) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (edge_s) begin
                    run_d   = CountWidth'(1);
                    sat_d   = 1'b0;
                    gap_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (edge_s) begin
                    gap_d = '0;
                    if (run_q == CNT_MAX) sat_d = 1'b1;
                    else                  run_d = run_q + 1'b1;
                end else if (!in_q) begin
                    gap_d = gap_q + 1'b1;
                end
                // A coincident edge is already folded into run_d, so it is part of the load.
                if (tos_eff) begin
                    load     = 1'b1;
                    late_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (!in_q && gap_q == GAP_LAST) begin
                    load    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_QUIET;
        endcase
    end

    always_ff @(posedge clk_tf) begin
        if (rst) begin
            state_q <= S_QUIET;
            in_q    <= 1'b0;
            in_p    <= 1'b0;
            gap_q   <= '0;
            run_q   <= '0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            osat_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= din;
            in_p    <= in_q;
            gap_q   <= gap_d;
            run_q   <= run_d;
            sat_q   <= sat_d;
            if (load) begin
                data_q  <= run_d;
                osat_q  <= sat_d;
                valid_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            ovr_q  <= ovr_set  | (ovr_q  & ~clr_flags);
            perr_q <= perr_set | (perr_q & ~clr_flags);
            lerr_q <= late_set | (lerr_q & ~clr_flags);
        end
    end

    assign count_data  = data_q;
    assign count_sat   = osat_q;
    assign count_valid = valid_q;
    assign overrun_err = ovr_q;
    assign pulse_err   = perr_q;
    assign late_err    = lerr_q;
endmodule

// File: doc/stop_count_rx.md
Name: stop_count_rx

Overview:
- Receiver/decoder for the serial stop-delay count on stop_tos_count: the transmitter sends N one-cycle high pulses, each followed by at least one low cycle, with N = slow-clock periods elapsed before the raw PPS edge.
- Block counts pulses, detects end of burst by a low-gap timeout and presents the decoded count on a valid/ready interface.
- Sits on clk_tf beside the timing core.
- Feeds the DDC/capture logic, which tags each second with its stop offset.

Parameters:
- CountWidth, 14: width of decoded count; ceil(log2(10000 slow clocks/s)).
- GapCycles, 4: consecutive low samples that terminate a burst (>=2).

Ports:
- clk_tf  input  1  system clock, 19.2 MHz.
- rst  input  1  synchronous reset, active-high.
- stop_tos_count  input  1  serial pulse train from the timing core.
- tos_mark  input  1  one-cycle top-of-second marker.
- count_data  output  CountWidth  decoded pulse count.
- count_sat  output  1  qualifies count_data; burst exceeded 2^CountWidth-1 pulses.
- count_valid  output  1  count_data/count_sat hold a result.
- count_ready  input  1  consumer accepts when valid & ready.
- overrun_err  output  1  sticky; an unaccepted result was overwritten.
- pulse_err  output  1  sticky; input high for 2+ consecutive samples.
- late_err  output  1  sticky; tos_mark arrived mid-burst.
- clr_flags  input  1  one-cycle clear of all sticky flags.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk_tf. All outputs are 0 in the cycle after rst is sampled high. Internal count, gap counter and input registers are 0. FSM enters S_QUIET.
- Input stage: in_q <= stop_tos_count; in_p <= in_q. Pulse edge = in_q & !in_p. Sample latency is 1 cycle.
- FSM S_QUIET: counts consecutive in_q==0 samples, restarting on any high sample. After GapCycles low samples it goes to S_IDLE. This discards partial bursts after reset.
- FSM S_IDLE: on an edge, run_cnt <= 1, gap <= 0, go to S_COUNT.
- FSM S_COUNT:
  - On an edge, run_cnt increments, saturating at 2^CountWidth-1; the saturation bit is set on the increment that would wrap. gap <= 0.
  - On an in_q==0 sample, gap increments. When gap==GapCycles-1 and in_q==0, the result loads and the FSM returns to S_IDLE.
- Load: count_data <= run_cnt and count_sat <= sat in the same edge; count_valid=1 the next cycle.
- Latency: last input pulse at cycle t gives count_valid high at cycle t+2+GapCycles (t+6 at default).
- Zero count: a burst of 0 pulses produces no result. The consumer treats a missing result before tos_mark as count 0.
- tos_mark in S_COUNT: immediate load of the current run_cnt, late_err set, FSM to S_IDLE.
- Edge coincident with tos_mark in S_COUNT: the edge is included in the loaded count.
- tos_mark in S_IDLE or S_QUIET: ignored.
- Handshake: transfer on count_valid & count_ready. count_valid falls the next cycle unless a load occurs the same cycle.
  - Data stays stable while valid & !ready.
  - Load with count_valid=1 and count_ready=0: data is overwritten, valid stays 1, overrun_err set.
  - Load with transfer in the same cycle: no overrun.
- pulse_err: set when in_q & in_p in S_IDLE or S_COUNT. A long high counts as a single pulse.
- Sticky flags: cleared by clr_flags. A set in the same cycle as clr_flags wins.
- Reset mid-burst: discards run_cnt and any pending result, then returns to S_QUIET.

Optional Feature:
- Macro STOP_COUNT_RX_SYNC_EN.
- Defined: stop_tos_count passes through a 2-flop synchronizer before in_q (for use when the source is off-chip or another domain). All latencies grow by 2 cycles; tos_mark is unsynchronized but delayed 2 cycles to stay aligned.
- Undefined: direct single register as above.

Test Plan:
- Reset, 4 low cycles, 5 pulses (1,0 pattern), then low: count_valid high 6 cycles after last pulse, count_data=5, count_sat=0, all flags 0.
- count_ready held 0, two bursts of 3 then 7 separated by 10 low cycles: count_data=7, overrun_err=1; ready=1 gives one transfer, then count_valid=0.
- Burst of 16385 pulses: count_data=16383, count_sat=1.
- Burst of 3 pulses with tos_mark on the cycle of the 3rd edge: immediate load count_data=3, late_err=1; further pulses start a new burst.
- Input held high 3 cycles inside a burst of 2 single pulses: count_data=3, pulse_err=1. clr_flags with no new error clears it to 0.
- rst asserted mid-burst after 4 pulses, released while 3 pulses remain: those 3 pulses are discarded (S_QUIET sees highs). The next clean burst of 2 gives count_data=2.
